// File: rtl/clock_set_ctrl_pkg.sv
// Shared state encodings and button indices for the clock setter
// and the display block.
package clock_set_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_HOUR = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;

  localparam int BTN_MODE = 0;
  localparam int BTN_UP   = 1;
  localparam int BTN_SCLR = 2;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_cnt.sv
// Two-digit packed BCD counter, 00..MAX, with wrap carry.
// Digits are stepped directly in BCD so no binary value is ever held.
module bcd_cnt
  import clock_set_ctrl_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] val,
  output logic       carry
);

  localparam logic [7:0] MAX_BCD = to_bcd(MAX);

  logic [7:0] val_q;
  logic [7:0] val_d;
  logic       at_max;

  assign at_max = (val_q == MAX_BCD);

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = 8'h00;
    end else if (inc) begin
      if (at_max) begin
        val_d = 8'h00;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= 8'h00;
    else     val_q <= val_d;
  end

  assign val   = val_q;
  assign carry = inc & ~clr & at_max;

endmodule

// File: rtl/clock_set_ctrl.sv
// 24h BCD time-of-day clock with MODE/UP/SCLR setting buttons
// and a 2 Hz blank strobe for the field under edit.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] BTN,
  output logic [7:0] HOUR,
  output logic [7:0] MIN,
  output logic [7:0] SEC,
  output logic [1:0] SETMODE,
  output logic       BLINK
);

  localparam int PW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int BDIV = (CLK_FREQ >= 4) ? (CLK_FREQ / 4) : 1;
  localparam int BW   = (BDIV > 1) ? $clog2(BDIV) : 1;

  localparam logic [PW-1:0] PRE_TC = PW'(CLK_FREQ - 1);
  localparam logic [BW-1:0] BLK_TC = BW'(BDIV - 1);

  logic          armed_q, armed_d;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q,  tick_d;
  logic [BW-1:0] bcnt_q,  bcnt_d;
  logic          blink_q, blink_d;

  logic [2:0] btn_v;
  logic       mode, up, sclr;
  logic       is_run, is_hset, is_mset;
  logic       inc_s, inc_m, inc_h, clr_s;
  logic       c_sec, c_min;

  // A pulse coinciding with reset release is masked for one edge.
  assign btn_v = armed_q ? BTN : 3'b000;
  assign mode  = btn_v[BTN_MODE];
  assign up    = btn_v[BTN_UP]   & ~mode;
  assign sclr  = btn_v[BTN_SCLR] & ~mode;

  assign is_hset = (state_q == ST_SET_HOUR);
  assign is_mset = (state_q == ST_SET_MIN);
  assign is_run  = ~(is_hset | is_mset);

  always_comb begin
    armed_d = 1'b1;
    state_d = ST_RUN;
    unique case (1'b1)
      is_hset: state_d = mode ? ST_SET_MIN : ST_SET_HOUR;
      is_mset: state_d = mode ? ST_RUN : ST_SET_MIN;
      default: state_d = mode ? ST_SET_HOUR : ST_RUN;
    endcase
  end

  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (is_run) begin
      tick_d  = (presc_q == PRE_TC);
      presc_d = tick_d ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    bcnt_d  = '0;
    blink_d = 1'b0;
    if (!is_run && state_d == state_q) begin
      if (bcnt_q == BLK_TC) begin
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      armed_q <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      armed_q <= armed_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign inc_s = is_run & tick_q;
  assign clr_s = ~is_run & sclr;
  assign inc_m = (is_run & c_sec) | (is_mset & up);
  assign inc_h = (is_run & c_min) | (is_hset & up);

  bcd_cnt #(.MAX(59)) u_sec (
    .clk   (CLK),
    .rst   (RST),
    .inc   (inc_s),
    .clr   (clr_s),
    .val   (SEC),
    .carry (c_sec)
  );

  bcd_cnt #(.MAX(59)) u_min (
    .clk   (CLK),
    .rst   (RST),
    .inc   (inc_m),
    .clr   (1'b0),
    .val   (MIN),
    .carry (c_min)
  );

  bcd_cnt #(.MAX(23)) u_hour (
    .clk   (CLK),
    .rst   (RST),
    .inc   (inc_h),
    .clr   (1'b0),
    .val   (HOUR),
    .carry ()
  );

  assign SETMODE = state_q;
  assign BLINK   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl at CLK_FREQ=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_clock_set_ctrl;

  logic       CLK;
  logic       RST;
  logic [2:0] BTN;
  logic [7:0] HOUR, MIN, SEC;
  logic [1:0] SETMODE;
  logic       BLINK;

  int n_cmp = 0;
  int n_err = 0;

  clock_set_ctrl #(.CLK_FREQ(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BTN     (BTN),
    .HOUR    (HOUR),
    .MIN     (MIN),
    .SEC     (SEC),
    .SETMODE (SETMODE),
    .BLINK   (BLINK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [2:0] b);
    BTN = b;
    @(negedge CLK);
    BTN = 3'b000;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hour"}, HOUR, 8'h00);
    chk({tag, "_min"},  MIN,  8'h00);
    chk({tag, "_sec"},  SEC,  8'h00);
    chk({tag, "_mode"}, {6'd0, SETMODE}, 8'h00);
    chk({tag, "_blink"}, {7'd0, BLINK}, 8'h00);
  endtask

  // Async reset check, then release; returns after first edge.
  task automatic do_reset(input string tag);
    RST = 1'b1;
    #1;
    chk_zero(tag);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    BTN = 3'b000;
    repeat (2) @(negedge CLK);
    chk_zero("por");

    // MODE coinciding with release is dropped
    RST = 1'b0;
    BTN = 3'b001;
    @(negedge CLK);
    BTN = 3'b000;
    chk("rel_mask", {6'd0, SETMODE}, 8'h00);

    press(3'b010);
    chk("run_up_ign", HOUR, 8'h00);
    press(3'b100);
    chk("run_sclr_ign", SEC, 8'h00);

    press(3'b001);
    chk("to_hset", {6'd0, SETMODE}, 8'h01);
    chk("blk_0", {7'd0, BLINK}, 8'h00);
    @(negedge CLK); chk("blk_1", {7'd0, BLINK}, 8'h00);
    @(negedge CLK); chk("blk_2", {7'd0, BLINK}, 8'h01);
    @(negedge CLK); chk("blk_3", {7'd0, BLINK}, 8'h01);
    @(negedge CLK); chk("blk_4", {7'd0, BLINK}, 8'h00);
    for (int i = 0; i < 25; i++) press(3'b010);
    chk("h25_hour", HOUR, 8'h01);
    chk("h25_min",  MIN,  8'h00);
    chk("h25_sec",  SEC,  8'h00);

    // Set 23:59:00, run, expect rollover at midnight
    do_reset("rst_b");
    press(3'b001);
    for (int i = 0; i < 23; i++) press(3'b010);
    chk("b_hour23", HOUR, 8'h23);
    press(3'b001);
    for (int i = 0; i < 59; i++) press(3'b010);
    chk("b_min59", MIN, 8'h59);
    chk("b_sec00", SEC, 8'h00);
    chk("b_smin", {6'd0, SETMODE}, 8'h02);
    press(3'b001);
    chk("b_run", {6'd0, SETMODE}, 8'h00);
    chk("b_run_blk", {7'd0, BLINK}, 8'h00);
    repeat (8) @(negedge CLK);
    chk("b_pre_tick", SEC, 8'h00);
    @(negedge CLK);
    chk("b_tick1", SEC, 8'h01);
    repeat (463) @(negedge CLK);
    chk("b_sec58", SEC, 8'h58);
    @(negedge CLK);
    chk("b_2359_h", HOUR, 8'h23);
    chk("b_2359_m", MIN,  8'h59);
    chk("b_2359_s", SEC,  8'h59);
    repeat (8) @(negedge CLK);
    chk("b_wrap_h", HOUR, 8'h00);
    chk("b_wrap_m", MIN,  8'h00);
    chk("b_wrap_s", SEC,  8'h00);

    // Edit with seconds running, then clear seconds
    do_reset("rst_c");
    repeat (29) @(negedge CLK);
    chk("c_sec03", SEC, 8'h03);
    press(3'b001);
    chk("c_hset", {6'd0, SETMODE}, 8'h01);
    repeat (3) @(negedge CLK);
    chk("c_frozen", SEC, 8'h03);
    BTN = 3'b010;
    repeat (5) @(negedge CLK);
    BTN = 3'b000;
    chk("c_wide_up", HOUR, 8'h05);
    press(3'b011);
    chk("c_modeup_st", {6'd0, SETMODE}, 8'h02);
    chk("c_modeup_h", HOUR, 8'h05);
    chk("c_mblk_0", {7'd0, BLINK}, 8'h00);
    @(negedge CLK); chk("c_mblk_1", {7'd0, BLINK}, 8'h00);
    @(negedge CLK); chk("c_mblk_2", {7'd0, BLINK}, 8'h01);
    for (int i = 0; i < 59; i++) press(3'b010);
    chk("c_0559_h", HOUR, 8'h05);
    chk("c_0559_m", MIN,  8'h59);
    chk("c_0559_s", SEC,  8'h03);
    press(3'b010);
    chk("c_mwrap_m", MIN,  8'h00);
    chk("c_mwrap_h", HOUR, 8'h05);
    press(3'b100);
    chk("c_sclr_s", SEC, 8'h00);
    chk("c_sclr_m", MIN, 8'h00);
    press(3'b110);
    chk("c_upsclr_m", MIN, 8'h01);
    chk("c_upsclr_s", SEC, 8'h00);

    do_reset("rst_mid");
    chk("post_rst_mode", {6'd0, SETMODE}, 8'h00);
    chk("post_rst_blk", {7'd0, BLINK}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
